// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: sequences weight loads and activation streaming into the
// weight-stationary MAC array, stalls on output-FIFO backpressure and waits
// for the last column to drain before pulsing done.
module mac_array_ctrl #(
    parameter int unsigned col     = 8,
    parameter int unsigned bw      = 8,
    parameter int unsigned pr      = 8,
    parameter int unsigned addr_bw = 11,
    parameter int unsigned len_bw  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [len_bw-1:0]    n_vec,
    input  logic                 ofifo_full,
    input  logic [col-1:0]       fifo_wr,
    output logic                 mem_rd,
    output logic [addr_bw-1:0]   mem_addr,
    input  logic [pr*bw-1:0]     mem_rdata,
    output logic [pr*bw-1:0]     array_in,
    output logic [1:0]           array_inst,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned DW = pr * bw;

    localparam logic [1:0] INST_NONE = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXEC,
        DRAIN,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [addr_bw-1:0]  addr_q, addr_d;
    logic [len_bw-1:0]   nvec_q, nvec_d;
    logic [len_bw-1:0]   wcnt_q, wcnt_d;
    logic [1:0]          ph_q, ph_d;
    logic [1:0]          inst_q, inst_d;
    logic [DW-1:0]       data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rd_c;
    logic                load_last_c;
    logic                exec_last_c;
    logic                unused_fifo_wr;

    // Only the last column's strobe marks a result that has fully left the array.
    assign unused_fifo_wr = ^fifo_wr[col-2:0];

    // Final weight row sits at col-1; final activation row at col+n_vec-1.
    assign load_last_c = (addr_q == addr_bw'(col - 1));
    assign exec_last_c = ((addr_q + addr_bw'(1)) == (addr_bw'(col) + addr_bw'(nvec_q)));

    // Next-state, read issue, completion counting and the instruction/data pipeline.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nvec_d  = nvec_q;
        wcnt_d  = wcnt_q;
        rd_c    = 1'b0;
        ph_d    = INST_NONE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    nvec_d  = n_vec;
                    wcnt_d  = '0;
                    addr_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                rd_c   = 1'b1;
                ph_d   = INST_LOAD;
                addr_d = addr_q + addr_bw'(1);
                if (load_last_c) begin
                    state_d = (nvec_q != '0) ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (!ofifo_full) begin
                    rd_c   = 1'b1;
                    ph_d   = INST_EXEC;
                    addr_d = addr_q + addr_bw'(1);
                    if (exec_last_c) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (wcnt_q == nvec_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (((state_q == EXEC) || (state_q == DRAIN)) && fifo_wr[col-1] && (wcnt_q != nvec_q)) begin
            wcnt_d = wcnt_q + len_bw'(1);
        end

        inst_d = ph_q;
        data_d = (ph_q != INST_NONE) ? mem_rdata : '0;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            nvec_q  <= '0;
            wcnt_q  <= '0;
            ph_q    <= INST_NONE;
            inst_q  <= INST_NONE;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nvec_q  <= nvec_d;
            wcnt_q  <= wcnt_d;
            ph_q    <= ph_d;
            inst_q  <= inst_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign mem_rd     = rd_c;
    assign mem_addr   = addr_q;
    assign array_in   = data_q;
    assign array_inst = inst_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
